// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: funct3 encodings, FSM states,
// and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, LOAD, MERGE, DONE} lsu_state_t;

    function automatic logic is_illegal(input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

    // Size comes from funct3[1:0]; byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-request, response and RAM-port bundle for dmem_lsu; slave = LSU side, master = core+RAM side.
// DMEM_BYTE_ENABLE_EN adds the mem_be byte-strobe signal.
interface dmem_lsu_if #(
    parameter int n  = 32,
    parameter int AW = 10
);
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [2:0]     req_funct3;
    logic [n-1:0]   req_addr;
    logic [31:0]    req_wdata;

    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;

    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;

`ifdef DMEM_BYTE_ENABLE_EN
    logic [3:0]     mem_be;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
    );
`else
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
`endif

endinterface

// File: rtl/dmem_lsu_lane.sv
// Combinational byte-lane logic: load extraction with sign/zero extension, and
// sub-word store merge into a previously read RAM word. Zero latency, no flow control.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [31:0] shifted;

    // Halfwords are aligned, so a byte-granular shift also selects the right half.
    assign shifted = rdata >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merge_data = rdata;
        case (funct3[1:0])
            2'b00:   merge_data[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merge_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for the word-wide DMEM: load/SW/error respond 1 cycle after accept, SB/SH 2 (1 with
// DMEM_BYTE_ENABLE_EN); one request at a time, req_ready only in IDLE so the core stalls until rsp_valid.
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter  int n       = 32,
    parameter  int N_WORDS = 1024,
    localparam int AW      = $clog2(N_WORDS)
) (
    input  logic        CLK,
    input  logic        RESET_N,
    dmem_lsu_if.slave   bus
);

    lsu_state_t     state;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic [AW-1:0]  waddr_q;
    logic [31:0]    wdata_q;
    logic           err_q;

    logic [1:0]     req_off;
    logic [AW-1:0]  req_waddr;
    logic           req_bad;
    logic           req_sw;
    logic           accept;
    logic [31:0]    load_data;
    logic [31:0]    merge_data;
    logic           unused_addr_hi;

    assign req_off        = bus.req_addr[1:0];
    assign req_waddr      = bus.req_addr[AW+1:2];
    assign unused_addr_hi = ^bus.req_addr[n-1:AW+2];
    assign req_bad        = is_illegal(bus.req_funct3) || is_misaligned(bus.req_funct3, req_off);
    assign req_sw         = bus.req_funct3[1:0] == 2'b10;
    assign accept         = RESET_N && (state == IDLE) && bus.req_valid;

    lsu_lane u_lane (
        .funct3     (f3_q),
        .off        (off_q),
        .rdata      (bus.mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q    <= bus.req_funct3;
                        off_q   <= req_off;
                        waddr_q <= req_waddr;
                        wdata_q <= bus.req_wdata;
                        err_q   <= req_bad;
                        if (req_bad || (bus.req_we && req_sw))
                            state <= DONE;
                        else if (!bus.req_we)
                            state <= LOAD;
                        else
`ifdef DMEM_BYTE_ENABLE_EN
                            state <= DONE;
`else
                            state <= MERGE;
`endif
                    end
                end
                LOAD:    state <= IDLE;
                MERGE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Gating on RESET_N keeps a reset landing mid-MERGE from writing a half-merged word.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
`ifdef DMEM_BYTE_ENABLE_EN
        bus.mem_be    = 4'b0000;
`endif
        if (RESET_N) begin
            case (state)
                IDLE: begin
                    bus.req_ready = 1'b1;
                    if (bus.req_valid && !req_bad) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = req_waddr;
                        if (bus.req_we && req_sw) begin
                            bus.mem_we    = 1'b1;
                            bus.mem_wdata = bus.req_wdata;
`ifdef DMEM_BYTE_ENABLE_EN
                            bus.mem_be    = 4'b1111;
                        end else if (bus.req_we) begin
                            bus.mem_we = 1'b1;
                            if (bus.req_funct3[0]) begin
                                bus.mem_wdata = {2{bus.req_wdata[15:0]}};
                                bus.mem_be    = req_off[1] ? 4'b1100 : 4'b0011;
                            end else begin
                                bus.mem_wdata = {4{bus.req_wdata[7:0]}};
                                bus.mem_be    = 4'b0001 << req_off;
                            end
`endif
                        end
                    end
                end
                LOAD: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = load_data;
                end
                MERGE: begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = waddr_q;
                    bus.mem_wdata = merge_data;
                end
                DONE: begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: behavioural DMEM model plus hand-computed expectations for
// reset, loads, sub-word store, errors, reset mid-merge and back-to-back requests.
module tb_dmem_lsu;
    import lsu_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   en_cnt = 0;
    int   we_cnt = 0;

    logic [31:0] ram [0:1023];

    dmem_lsu_if #(.n(32), .AW(10)) bus ();

    dmem_lsu #(.n(32), .N_WORDS(1024)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (bus.mem_en) begin
            en_cnt++;
            if (bus.mem_we) begin
                we_cnt++;
`ifdef DMEM_BYTE_ENABLE_EN
                for (int k = 0; k < 4; k++)
                    if (bus.mem_be[k]) ram[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
`else
                ram[bus.mem_addr] <= bus.mem_wdata;
`endif
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        repeat (2) begin
            @(negedge CLK);
            n_cmp++;
            if ({bus.req_ready, bus.mem_en, bus.rsp_valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_ctl ready/en/vld got=%b want=000", {bus.req_ready, bus.mem_en, bus.rsp_valid});
            end
            n_cmp++;
            if ({bus.mem_we, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin
                n_bad++;
                $display("FAIL reset_rsp we/err/rdata got=%b/%b/%h want=0/0/0", bus.mem_we, bus.rsp_err, bus.rsp_rdata);
            end
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge CLK);
        n_cmp++;
        if ({bus.req_ready, bus.mem_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release ready/en got=%b want=10", {bus.req_ready, bus.mem_en});
        end
    endtask

    logic [2:0]  ld_f3   [6] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W, F3_W};
    logic [31:0] ld_addr [6] = '{32'h10, 32'h11, 32'h12, 32'h12, 32'h10, 32'h1010};
    logic [31:0] ld_exp  [6] = '{32'hFFFF_FFAA, 32'h0000_00F0, 32'hFFFF_8001,
                                 32'h0000_8001, 32'h8001_F0AA, 32'h8001_F0AA};

    task automatic test_loads();
        ram[4] = 32'h8001_F0AA;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            drive(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0);
            @(negedge CLK);
            n_cmp++;
            if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 10'd4}) begin
                n_bad++;
                $display("FAIL load%0d_req en/we/addr got=%b/%b/%h want=1/0/004", i, bus.mem_en, bus.mem_we, bus.mem_addr);
            end
            @(negedge CLK);
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.rsp_rdata} !== {3'b100, ld_exp[i]}) begin
                n_bad++;
                $display("FAIL load%0d_rsp vld/err/rdy/rdata got=%b/%b/%b/%h want=1/0/0/%h",
                         i, bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.rsp_rdata, ld_exp[i]);
            end
            @(posedge CLK); #1;
            drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        end
    endtask

    task automatic test_store_byte();
        ram[4] = 32'h1122_3344;
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, F3_B, 32'h13, 32'hABCD_EF5C);
        @(negedge CLK);
`ifdef DMEM_BYTE_ENABLE_EN
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {2'b11, 4'b1000, 32'h5C5C_5C5C}) begin
            n_bad++;
            $display("FAIL sb_write en/we/be/wdata got=%b/%b/%b/%h want=1/1/1000/5c5c5c5c",
                     bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_wdata);
        end
`else
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 10'd4}) begin
            n_bad++;
            $display("FAIL sb_read en/we/addr got=%b/%b/%h want=1/0/004", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(negedge CLK);
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.rsp_valid, bus.mem_addr, bus.mem_wdata} !== {3'b110, 10'd4, 32'h5C22_3344}) begin
            n_bad++;
            $display("FAIL sb_merge en/we/vld/addr/wdata got=%b/%b/%b/%h/%h want=1/1/0/004/5c223344",
                     bus.mem_en, bus.mem_we, bus.rsp_valid, bus.mem_addr, bus.mem_wdata);
        end
`endif
        @(negedge CLK);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.rsp_rdata} !== {3'b100, 32'h0}) begin
            n_bad++;
            $display("FAIL sb_rsp vld/err/en/rdata got=%b/%b/%b/%h want=1/0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.mem_en, bus.rsp_rdata);
        end
        n_cmp++;
        if (ram[4] !== 32'h5C22_3344) begin
            n_bad++;
            $display("FAIL sb_ram got=%h want=5c223344", ram[4]);
        end
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'h5C22_3344}) begin
            n_bad++;
            $display("FAIL sb_reread vld/rdata got=%b/%h want=1/5c223344", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    logic        er_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  er_f3   [3] = '{F3_W, F3_H, 3'b011};
    logic [31:0] er_addr [3] = '{32'h06, 32'h01, 32'h00};

    task automatic test_errors();
        for (int i = 0; i < 3; i++) begin
            int c0;
            @(posedge CLK); #1;
            c0 = en_cnt;
            drive(1'b1, er_we[i], er_f3[i], er_addr[i], 32'hFFFF_FFFF);
            @(negedge CLK);
            n_cmp++;
            if ({bus.req_ready, bus.mem_en, bus.mem_we} !== 3'b100) begin
                n_bad++;
                $display("FAIL err%0d_req rdy/en/we got=%b want=100", i, {bus.req_ready, bus.mem_en, bus.mem_we});
            end
            @(negedge CLK);
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {2'b11, 32'h0}) begin
                n_bad++;
                $display("FAIL err%0d_rsp vld/err/rdata got=%b/%b/%h want=1/1/0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
            end
            @(posedge CLK); #1;
            drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
            n_cmp++;
            if (en_cnt !== c0) begin
                n_bad++;
                $display("FAIL err%0d_noaccess mem_en cycles got=%0d want=0", i, en_cnt - c0);
            end
        end
    endtask

    task automatic test_reset_merge();
`ifndef DMEM_BYTE_ENABLE_EN
        int w0;
        ram[5] = 32'hCAFE_BABE;
        @(posedge CLK); #1;
        w0 = we_cnt;
        drive(1'b1, 1'b1, F3_H, 32'h16, 32'h0000_1234);
        @(negedge CLK);
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {2'b10, 10'd5}) begin
            n_bad++;
            $display("FAIL rm_read en/we/addr got=%b/%b/%h want=1/0/005", bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.rsp_valid} !== 3'b000) begin
            n_bad++;
            $display("FAIL rm_suppress en/we/vld got=%b want=000", {bus.mem_en, bus.mem_we, bus.rsp_valid});
        end
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        @(negedge CLK);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL rm_idle rdy/vld got=%b want=10", {bus.req_ready, bus.rsp_valid});
        end
        n_cmp++;
        if ((ram[5] !== 32'hCAFE_BABE) || (we_cnt !== w0)) begin
            n_bad++;
            $display("FAIL rm_ram word=%h writes=%0d want=cafebabe/0", ram[5], we_cnt - w0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        @(posedge CLK); #1;
        drive(1'b1, 1'b1, F3_W, 32'h20, 32'hDEAD_BEEF);
        @(negedge CLK);
        n_cmp++;
        if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 10'd8, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL b2b_sw en/we/addr/wdata got=%b/%b/%h/%h want=1/1/008/deadbeef",
                     bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
`ifdef DMEM_BYTE_ENABLE_EN
        n_cmp++;
        if (bus.mem_be !== 4'b1111) begin
            n_bad++;
            $display("FAIL b2b_sw_be got=%b want=1111", bus.mem_be);
        end
`endif
        @(negedge CLK);
        n_cmp++;
        if ({bus.rsp_valid, bus.req_ready, bus.rsp_err} !== 3'b100) begin
            n_bad++;
            $display("FAIL b2b_sw_rsp vld/rdy/err got=%b want=100", {bus.rsp_valid, bus.req_ready, bus.rsp_err});
        end
        @(posedge CLK); #1;
        drive(1'b1, 1'b0, F3_W, 32'h20, 32'h0);
        @(negedge CLK);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b1010, 10'd8}) begin
            n_bad++;
            $display("FAIL b2b_lw_req rdy/vld/en/we/addr got=%b/%b/%b/%b/%h want=1/0/1/0/008",
                     bus.req_ready, bus.rsp_valid, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        @(negedge CLK);
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL b2b_lw_rsp vld/rdata got=%b/%h want=1/deadbeef", bus.rsp_valid, bus.rsp_rdata);
        end
        @(posedge CLK); #1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        test_reset();
        test_loads();
        test_store_byte();
        test_errors();
        test_reset_merge();
        test_back_to_back();
        @(posedge CLK); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the single-cycle core's data port and the word-wide synchronous data RAM (DMEM).
- Accepts one RISC-V load/store request at a time; handles LB/LH/LW/LBU/LHU/SB/SH/SW sizing, byte-lane alignment and sign/zero extension.
- Sub-word stores are done by read-modify-write; the core is stalled through a valid/ready handshake.

Parameters:
- n, 32, byte-address width of req_addr.
- N_WORDS, 1024, RAM depth in 32-bit words.
- AW, $clog2(N_WORDS), word-address width (derived; not overridden).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  synchronous active-low reset, sampled on rising edge of CLK.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign field.
- req_addr  in  n  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle pulse; operation complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned address or illegal funct3; valid with rsp_valid.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  word address = req_addr[AW+1:2]; upper bits ignored (wrap).
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data; valid one cycle after a read with mem_en=1, mem_we=0.

Behaviour:
- Handshake:
  - An accept occurs when req_valid && req_ready.
  - The request is latched into internal registers at the accept.
  - The core holds its request until it sees rsp_valid.
- FSM states: IDLE, LOAD, MERGE, DONE.
- Accept in IDLE at cycle T:
  - Illegal funct3 (011, 110, 111): no RAM access; go to DONE.
  - Misaligned access (halfword with addr[0]=1, or word with addr[1:0]!=0): no RAM access; go to DONE with err flag set.
  - Load: mem_en=1, mem_we=0 at T; go to LOAD.
  - SW: mem_en=1, mem_we=1, mem_wdata=req_wdata at T; go to DONE.
  - SB/SH: mem_en=1, mem_we=0 (read of the old word) at T; go to MERGE.
- LOAD at T+1:
  - rsp_valid=1.
  - rsp_rdata = selected lane of mem_rdata, shifted by addr[1:0], sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - Next state IDLE.
- MERGE at T+1:
  - mem_en=1, mem_we=1, mem_addr = latched word address.
  - mem_wdata = mem_rdata with the target byte or halfword lane replaced by the low bits of latched wdata.
  - Next state DONE.
- DONE: rsp_valid=1, rsp_err = latched err flag, rsp_rdata=0; next state IDLE.
- Latencies: load 1 cycle, SW 1 cycle, SB/SH 2 cycles, error 1 cycle (rsp_valid cycles after accept).
- Outputs outside the listed cases: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_*=0.
- req_valid low in IDLE: stay in IDLE; all mem_* outputs 0.
- Reset (RESET_N=0 at an edge):
  - State goes to IDLE; latched request registers cleared.
  - While RESET_N=0, combinationally: req_ready=0, mem_en=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Reset during MERGE suppresses the write; no partial store reaches RAM.
- Back-to-back: rsp_valid and req_ready are never high in the same cycle; a new accept is earliest in the cycle after rsp_valid.

Optional Feature:
- Macro: DMEM_BYTE_ENABLE_EN.
- Defined:
  - Extra port mem_be out 4 (byte write strobes).
  - SB/SH are done in one write cycle with a lane-replicated mem_wdata and the matching mem_be; MERGE is unused; SB/SH latency is 1.
  - SW drives mem_be=4'b1111.
  - mem_be=0 whenever mem_we=0.
- Undefined: no mem_be port; SB/SH use read-modify-write as described in Behaviour.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum lsu_state_t {IDLE, LOAD, MERGE, DONE}.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_lane (combinational) does load extraction/extension and store lane merge. It is shared by the LOAD path and the MERGE path.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles with req_valid=1 -> req_ready=0, mem_en=0, rsp_valid=0; after release req_ready=1.
- Loads from RAM word[4]=32'h8001_F0AA:
  - LB addr 0x10 -> rsp_rdata 32'hFFFF_FFAA at T+1.
  - LBU addr 0x11 -> 32'h0000_00F0.
  - LH addr 0x12 -> 32'hFFFF_8001.
  - LW addr 0x10 -> 32'h8001_F0AA.
- SB 8'h5C to addr 0x13 over word 32'h1122_3344 -> write at T+1 of 32'h5C22_3344; rsp_valid at T+2; re-read with LW returns it.
- Misaligned and illegal:
  - LW addr 0x06 -> rsp_err=1 at T+1, mem_en never asserted.
  - SH addr 0x01 -> same.
  - funct3=3'b011 -> same.
- Reset asserted during the MERGE of an SH -> mem_we stays 0; RAM word unchanged; FSM in IDLE after release.
- Back-to-back: SW then LW to the same address with req_valid held -> second accept one cycle after the first rsp_valid; LW returns the stored value.
